// File: rtl/sdram_rd_arbiter_pkg.sv
// rtl/sdram_rd_arbiter_pkg.sv - shared FSM encoding and source identifiers for the read arbiter
package sdram_rd_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

    localparam logic SRC_DATA = 1'b0;
    localparam logic SRC_PF   = 1'b1;

endpackage

// File: rtl/sdram_rd_arbiter_tag_fifo.sv
// rtl/sdram_rd_arbiter_tag_fifo.sv - 1-bit return-routing tag queue, DEPTH entries (power of 2)
module sdram_rd_arbiter_tag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A simultaneous pop frees the slot the push needs, so full only blocks a lone push.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_rd_arbiter.sv
// rtl/sdram_rd_arbiter.sv - round-robin read arbiter for data-path and prefetch sources sharing one SDRAM read port
module sdram_rd_arbiter
    import sdram_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_req,
    input  logic [ADDR_W-1:0] s0_addr,
    output logic              s0_gnt,
    input  logic              s1_req,
    input  logic [ADDR_W-1:0] s1_addr,
    output logic              s1_gnt,
    output logic              s1_rvalid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic              ctrl_in_valid,
    output logic [ADDR_W-1:0] ctrl_addr,
    input  logic              ctrl_in_ready,
    input  logic              ctrl_out_valid,
    input  logic [DATA_W-1:0] ctrl_dout,
    input  logic              abt_full_n,
    output logic              brc_in_valid,
    output logic [DATA_W-1:0] Di,
    output logic              err_orphan
);

    arb_state_t        r_state;
    logic              r_rr_ptr;
    logic              r_src;
    logic              r_d_busy;
    logic              r_ctrl_in_valid;
    logic [ADDR_W-1:0] r_ctrl_addr;
    logic              r_brc_in_valid;
    logic [DATA_W-1:0] r_di;
    logic              r_s1_rvalid;
    logic [DATA_W-1:0] r_s1_rdata;
    logic              r_err_orphan;

    logic w_tq_full;
    logic w_tq_empty;
    logic w_tq_head;
    logic w_e0;
    logic w_e1;
    logic w_grant;
    logic w_grant_src;
    logic w_issue_done;

    always_comb begin
        w_e0         = s0_req & ~r_d_busy & abt_full_n & ~w_tq_full;
        w_e1         = s1_req & ~w_tq_full;
        w_grant      = w_e0 | w_e1;
        w_grant_src  = (w_e0 & w_e1) ? r_rr_ptr : w_e1;
        w_issue_done = (r_state == ST_ISSUE) & ctrl_in_ready;
    end

    // Grants are qualified by the handshake itself so a requester can drop req on the very next edge.
    assign s0_gnt        = w_issue_done & (r_src == SRC_DATA);
    assign s1_gnt        = w_issue_done & (r_src == SRC_PF);
    assign ctrl_in_valid = r_ctrl_in_valid;
    assign ctrl_addr     = r_ctrl_addr;
    assign brc_in_valid  = r_brc_in_valid;
    assign Di            = r_di;
    assign s1_rvalid     = r_s1_rvalid;
    assign s1_rdata      = r_s1_rdata;
    assign err_orphan    = r_err_orphan;

    sdram_rd_arbiter_tag_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_tag_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_issue_done),
        .i_din  (r_src),
        .i_pop  (ctrl_out_valid),
        .o_full (w_tq_full),
        .o_empty(w_tq_empty),
        .o_head (w_tq_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= 1'b0;
            r_src           <= SRC_DATA;
            r_ctrl_in_valid <= 1'b0;
            r_ctrl_addr     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_src           <= w_grant_src;
                        r_ctrl_addr     <= w_grant_src ? s1_addr : s0_addr;
                        r_ctrl_in_valid <= 1'b1;
                        r_state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ctrl_in_ready) begin
                        r_ctrl_in_valid <= 1'b0;
                        r_rr_ptr        <= ~r_src;
                        r_state         <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // One data-path read at a time: the data FIFO holds a single entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_busy <= 1'b0;
        end else if (w_issue_done && (r_src == SRC_DATA)) begin
            r_d_busy <= 1'b1;
        end else if (r_brc_in_valid) begin
            r_d_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_brc_in_valid <= 1'b0;
            r_di           <= '0;
            r_s1_rvalid    <= 1'b0;
            r_s1_rdata     <= '0;
            r_err_orphan   <= 1'b0;
        end else begin
            r_brc_in_valid <= 1'b0;
            r_s1_rvalid    <= 1'b0;
            if (ctrl_out_valid) begin
                if (w_tq_empty) begin
                    r_err_orphan <= 1'b1;
                end else if (w_tq_head == SRC_DATA) begin
                    r_brc_in_valid <= 1'b1;
                    r_di           <= ctrl_dout;
                end else begin
                    r_s1_rvalid <= 1'b1;
                    r_s1_rdata  <= ctrl_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// tb/tb_sdram_rd_arbiter.sv - self-checking bench for sdram_rd_arbiter with requester, controller and data-FIFO models
module tb_sdram_rd_arbiter;

    localparam int ADDR_W    = 23;
    localparam int DATA_W    = 32;
    localparam int MAX_OUTST = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              s0_req, s1_req;
    logic [ADDR_W-1:0] s0_addr, s1_addr;
    logic              s0_gnt, s1_gnt;
    logic              s1_rvalid;
    logic [DATA_W-1:0] s1_rdata;
    logic              ctrl_in_valid;
    logic [ADDR_W-1:0] ctrl_addr;
    logic              ctrl_in_ready;
    logic              ctrl_out_valid;
    logic [DATA_W-1:0] ctrl_dout;
    logic              abt_full_n;
    logic              brc_in_valid;
    logic [DATA_W-1:0] Di;
    logic              err_orphan;

    sdram_rd_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s0_addr(s0_addr), .s0_gnt(s0_gnt),
        .s1_req(s1_req), .s1_addr(s1_addr), .s1_gnt(s1_gnt),
        .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata),
        .ctrl_in_valid(ctrl_in_valid), .ctrl_addr(ctrl_addr), .ctrl_in_ready(ctrl_in_ready),
        .ctrl_out_valid(ctrl_out_valid), .ctrl_dout(ctrl_dout),
        .abt_full_n(abt_full_n), .brc_in_valid(brc_in_valid), .Di(Di),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Environment knobs driven by the test sequence
    int  ready_mode;   // 0 low, 1 high, 2 random
    int  ret_pct;
    int  drain_pct;
    int  req_pct0, req_pct1;
    bit  ret_once, inject_orphan, fifo_block;

    logic [ADDR_W-1:0] cmd_q[$];
    logic [31:0]       data_ovr_q[$];
    bit                drv_orphan;
    logic              drv_src;
    logic [31:0]       drv_data;
    bit                exp_v;
    logic              exp_src;
    logic [31:0]       exp_data;
    bit                g0_seen, g1_seen, brc_seen, occ;
    int                g0_cnt, g1_cnt;

    function automatic logic [31:0] mkdata(input logic [ADDR_W-1:0] a);
        return {a, 9'h0} ^ 32'h5a5a_1234;
    endfunction

    function automatic logic [ADDR_W-1:0] rnd_addr(input logic src);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom);
        a[ADDR_W-1] = src;
        return a;
    endfunction

    // Requesters, SDRAM controller and 1-entry data FIFO, updated just after each rising edge
    initial begin : driver
        logic [ADDR_W-1:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (g0_seen) s0_req = 1'b0;
            if (g1_seen) s1_req = 1'b0;
            if (!s0_req && req_pct0 > 0 && $urandom_range(1, 100) <= req_pct0) begin
                s0_req = 1'b1; s0_addr = rnd_addr(1'b0);
            end
            if (!s1_req && req_pct1 > 0 && $urandom_range(1, 100) <= req_pct1) begin
                s1_req = 1'b1; s1_addr = rnd_addr(1'b1);
            end
            case (ready_mode)
                0:       ctrl_in_ready = 1'b0;
                1:       ctrl_in_ready = 1'b1;
                default: ctrl_in_ready = 1'($urandom_range(0, 1));
            endcase
            ctrl_out_valid = 1'b0;
            drv_orphan     = 1'b0;
            if (inject_orphan) begin
                inject_orphan  = 1'b0;
                ctrl_out_valid = 1'b1;
                ctrl_dout      = 32'hbad0_0bad;
                drv_orphan     = 1'b1;
            end else if (cmd_q.size() > 0 &&
                         (ret_once || (ret_pct > 0 && $urandom_range(1, 100) <= ret_pct))) begin
                ret_once       = 1'b0;
                a              = cmd_q.pop_front();
                ctrl_dout      = (data_ovr_q.size() > 0) ? data_ovr_q.pop_front() : mkdata(a);
                ctrl_out_valid = 1'b1;
                drv_src        = a[ADDR_W-1];
                drv_data       = ctrl_dout;
            end
            if (occ && $urandom_range(1, 100) <= drain_pct) occ = 1'b0;
            if (brc_seen) occ = 1'b1;
            abt_full_n = !(occ || fifo_block);
        end
    end

    // Scoreboard: source is encoded in address MSB; returns come back in issue order
    initial begin : monitor
        logic src;
        forever begin
            @(negedge clk);
            g0_seen  = s0_gnt;
            g1_seen  = s1_gnt;
            brc_seen = brc_in_valid;
            if (rst) begin
                exp_v = 1'b0;
            end else begin
                check("ret_brc", brc_in_valid, exp_v && !exp_src);
                check("ret_s1v", s1_rvalid, exp_v && exp_src);
                if (exp_v && !exp_src) check("ret_di", Di, exp_data);
                if (exp_v && exp_src)  check("ret_s1d", s1_rdata, exp_data);
                if (brc_in_valid) check("fifo_ovr", occ, 0);
                if (ctrl_in_valid && ctrl_in_ready) begin
                    src = ctrl_addr[ADDR_W-1];
                    check("hs_gnt", {s1_gnt, s0_gnt}, src ? 2'b10 : 2'b01);
                    check("hs_addr", ctrl_addr, src ? s1_addr : s0_addr);
                    cmd_q.push_back(ctrl_addr);
                    check("outst", cmd_q.size() <= MAX_OUTST, 1);
                    if (src) g1_cnt++; else g0_cnt++;
                end else begin
                    check("no_gnt", {s1_gnt, s0_gnt}, 0);
                end
                exp_v    = ctrl_out_valid && !drv_orphan;
                exp_src  = drv_src;
                exp_data = drv_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s0_req = 1'b0; s1_req = 1'b0;
        ready_mode = 0; ret_pct = 0; drain_pct = 100; req_pct0 = 0; req_pct1 = 0;
        ret_once = 1'b0; inject_orphan = 1'b0; fifo_block = 1'b0;
        cmd_q.delete(); data_ovr_q.delete(); occ = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int k, cnt;
        int order[$];
        rst = 1'b1; s0_req = 0; s1_req = 0; s0_addr = '0; s1_addr = '0;
        ctrl_in_ready = 0; ctrl_out_valid = 0; ctrl_dout = '0; abt_full_n = 1'b1;
        do_reset();

        // Orphan first, so the reset test also shows err_orphan clearing
        inject_orphan = 1'b1;
        repeat (3) tick();
        check("orph_pre", err_orphan, 1);

        // T1: asynchronous reset while a command is stuck in ISSUE
        s0_addr = 23'h000010; s0_req = 1'b1;
        k = 0;
        while (!ctrl_in_valid && k < 10) begin tick(); k++; end
        check("t1_issue", ctrl_in_valid, 1);
        repeat (2) tick();
        rst = 1'b1; s0_req = 1'b0;
        #1;
        check("t1_ctl", {s0_gnt, s1_gnt, s1_rvalid, ctrl_in_valid, brc_in_valid, err_orphan}, 0);
        check("t1_addr", ctrl_addr, 0);
        check("t1_di", Di, 0);
        check("t1_s1d", s1_rdata, 0);
        do_reset();

        // T2: single s0 read
        ready_mode = 1;
        s0_addr = 23'h000010; s0_req = 1'b1;
        tick();
        check("t2_civ", ctrl_in_valid, 1);
        check("t2_addr", ctrl_addr, 23'h000010);
        check("t2_gnt", s0_gnt, 1);
        data_ovr_q.push_back(32'hDEADBEEF);
        ret_once = 1'b1;
        tick();
        tick();
        check("t2_brc", brc_in_valid, 1);
        check("t2_di", Di, 32'hDEADBEEF);
        tick();
        check("t2_pulse", brc_in_valid, 0);
        check("t2_hold", Di, 32'hDEADBEEF);
        repeat (4) tick();

        // T3: both sources held, round-robin and in-order return routing
        do_reset();
        ready_mode = 1;
        for (int r = 0; r < 2; r++) begin
            data_ovr_q.push_back(32'hA + 2 * r);
            data_ovr_q.push_back(32'hB + 2 * r);
            s0_addr = 23'h000100 + 23'(r); s1_addr = 23'h400200 + 23'(r);
            s0_req = 1'b1; s1_req = 1'b1;
            order.delete();
            k = 0;
            while (order.size() < 2 && k < 20) begin
                tick();
                if (s0_gnt) order.push_back(0);
                if (s1_gnt) order.push_back(1);
                k++;
            end
            check("t3_first", (order.size() >= 1) ? order[0] : 9, 0);
            check("t3_second", (order.size() >= 2) ? order[1] : 9, 1);
            ret_pct = 100;
            k = 0;
            while (!brc_in_valid && k < 10) begin tick(); k++; end
            check("t3_di", Di, 32'hA + 2 * r);
            k = 0;
            while (!s1_rvalid && k < 10) begin tick(); k++; end
            check("t3_s1d", s1_rdata, 32'hB + 2 * r);
            ret_pct = 0;
            repeat (4) tick();
        end

        // T4: data FIFO full holds off s0
        fifo_block = 1'b1;
        repeat (2) tick();
        s0_addr = 23'h000777; s0_req = 1'b1;
        cnt = 0;
        repeat (20) begin tick(); if (s0_gnt) cnt++; end
        check("t4_block", cnt, 0);
        fifo_block = 1'b0;
        k = 0;
        while (!abt_full_n && k < 5) begin tick(); k++; end
        k = 0;
        while (!s0_gnt && k < 10) begin tick(); k++; end
        check("t4_lat", k <= 2, 1);
        ret_pct = 100;
        repeat (6) tick();
        ret_pct = 0;

        // T5: tag queue depth limits outstanding reads
        do_reset();
        ready_mode = 1; req_pct1 = 100;
        cnt = 0;
        repeat (15) begin tick(); if (s1_gnt) cnt++; end
        check("t5_cnt", cnt, MAX_OUTST);
        check("t5_stall", ctrl_in_valid, 0);
        ret_once = 1'b1;
        tick();
        tick();
        ret_once = 1'b1;
        cnt = 0;
        tick();
        check("t5_same", {s1_gnt, ctrl_out_valid}, 2'b11);
        if (s1_gnt) cnt++;
        repeat (14) begin tick(); if (s1_gnt) cnt++; end
        check("t5_cnt2", cnt, 2);
        req_pct1 = 0; ret_pct = 100;
        repeat (10) tick();
        ret_pct = 0;

        // T6: controller back-pressure, then an unsolicited return
        ready_mode = 0;
        s1_addr = 23'h4abcde; s1_req = 1'b1;
        k = 0;
        while (!ctrl_in_valid && k < 10) begin tick(); k++; end
        cnt = 0;
        repeat (5) begin
            tick();
            check("t6_addr", ctrl_addr, 23'h4abcde);
            if (s1_gnt) cnt++;
        end
        check("t6_nogt", cnt, 0);
        ready_mode = 1;
        cnt = 0;
        repeat (5) begin tick(); if (s1_gnt) cnt++; end
        check("t6_gnt", cnt, 1);
        ret_pct = 100;
        repeat (4) tick();
        ret_pct = 0;
        repeat (2) tick();
        check("t6_noerr", err_orphan, 0);
        inject_orphan = 1'b1;
        tick();
        tick();
        check("t6_nostb", {brc_in_valid, s1_rvalid}, 0);
        check("t6_orph", err_orphan, 1);
        repeat (5) tick();
        check("t6_sticky", err_orphan, 1);

        // Randomized traffic against the scoreboard
        do_reset();
        g0_cnt = 0; g1_cnt = 0;
        ready_mode = 2; ret_pct = 35; drain_pct = 50; req_pct0 = 30; req_pct1 = 30;
        repeat (3000) tick();
        req_pct0 = 0; req_pct1 = 0; ready_mode = 1; ret_pct = 100; drain_pct = 100;
        k = 0;
        while ((s0_req || s1_req || cmd_q.size() > 0) && k < 200) begin tick(); k++; end
        repeat (5) tick();
        check("rnd_drain", cmd_q.size(), 0);
        check("rnd_req", {s0_req, s1_req}, 0);
        check("rnd_g0", g0_cnt > 10, 1);
        check("rnd_g1", g1_cnt > 10, 1);
        check("rnd_orph", err_orphan, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
